// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the uart_core TX data register between NUM_REQ
// byte-stream requesters. Round-robin arbitration with packet locking; for
// every byte the status register is polled and exactly one TX write is issued
// once the TX FIFO reports not-full.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter logic [31:0] TXDATA_ADDR  = 32'hff00_020c,
    parameter logic [31:0] STATUS_ADDR  = 32'hff00_0208,
    parameter int unsigned TX_FULL_BIT  = 0,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    localparam int unsigned GW = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 bus_rd_en,
    output logic                 bus_wr_en,
    output logic [31:0]          bus_address,
    output logic [31:0]          bus_wr_data,
    input  logic [31:0]          bus_rd_data,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
);

    localparam int unsigned    CW       = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [GW:0]    NREQ_W   = (GW + 1)'(NUM_REQ);
    localparam logic [GW:0]    LAST_IDX = (GW + 1)'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_WAIT_RD,
        S_WRITE,
        S_LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic          busy_q, busy_d;
    logic          lock_q, lock_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          last_q, last_d;
    logic          bus_rd_en_q, bus_rd_en_d;
    logic          bus_wr_en_q, bus_wr_en_d;
    logic [31:0]   bus_address_q, bus_address_d;
    logic [31:0]   bus_wr_data_q, bus_wr_data_d;

    logic          scan_found;
    logic [GW-1:0] scan_pick;
    logic [GW:0]   scan_sum;
    logic          tx_full;
    logic          gnt_valid;
    logic [7:0]    gnt_data;
    logic          gnt_last;
    logic          unused_rd;

    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] g);
        if ({1'b0, g} == LAST_IDX) begin
            return '0;
        end
        return g + GW'(1);
    endfunction

    assign tx_full   = bus_rd_data[TX_FULL_BIT];
    assign gnt_valid = req_valid[grant_q];
    assign gnt_data  = req_data[{grant_q, 3'b000} +: 8];
    assign gnt_last  = req_last[grant_q];
    assign unused_rd = ^bus_rd_data;

    // Round-robin scan: first valid requester at or after the pointer, wrapping.
    always_comb begin
        scan_found = 1'b0;
        scan_pick  = '0;
        scan_sum   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, ptr_q} + (GW + 1)'(i);
            if (scan_sum >= NREQ_W) begin
                scan_sum = scan_sum - NREQ_W;
            end
            if (!scan_found && req_valid[scan_sum[GW-1:0]]) begin
                scan_found = 1'b1;
                scan_pick  = scan_sum[GW-1:0];
            end
        end
    end

    // Arbiter FSM next-state logic and the combinational accept strobe.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        last_d    = last_q;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (scan_found) begin
                    grant_d = scan_pick;
                    busy_d  = 1'b1;
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (tx_full) begin
                    state_d = S_POLL;
                end else if (gnt_valid) begin
                    req_ready[grant_q] = 1'b1;
                    byte_d  = gnt_data;
                    last_d  = gnt_last;
                    state_d = S_WRITE;
                end else if (lock_q) begin
                    state_d = S_LOCKED;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (last_q) begin
                    busy_d  = 1'b0;
                    lock_d  = 1'b0;
                    ptr_d   = wrap_inc(grant_q);
                    state_d = S_IDLE;
                end else begin
                    lock_d  = 1'b1;
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (gnt_valid) begin
                    cnt_d   = '0;
                    state_d = S_POLL;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    lock_d  = 1'b0;
                    ptr_d   = wrap_inc(grant_q);
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus strobes are registered, so they are derived from the state being entered.
    always_comb begin
        bus_rd_en_d   = 1'b0;
        bus_wr_en_d   = 1'b0;
        bus_address_d = '0;
        bus_wr_data_d = '0;
        if (state_d == S_POLL) begin
            bus_rd_en_d   = 1'b1;
            bus_address_d = STATUS_ADDR;
        end else if (state_d == S_WRITE) begin
            bus_wr_en_d   = 1'b1;
            bus_address_d = TXDATA_ADDR;
            bus_wr_data_d = {24'h0, byte_d};
        end
    end

    // State and bus output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            ptr_q         <= '0;
            busy_q        <= 1'b0;
            lock_q        <= 1'b0;
            cnt_q         <= '0;
            byte_q        <= '0;
            last_q        <= 1'b0;
            bus_rd_en_q   <= 1'b0;
            bus_wr_en_q   <= 1'b0;
            bus_address_q <= '0;
            bus_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
            busy_q        <= busy_d;
            lock_q        <= lock_d;
            cnt_q         <= cnt_d;
            byte_q        <= byte_d;
            last_q        <= last_d;
            bus_rd_en_q   <= bus_rd_en_d;
            bus_wr_en_q   <= bus_wr_en_d;
            bus_address_q <= bus_address_d;
            bus_wr_data_q <= bus_wr_data_d;
        end
    end

    assign bus_rd_en   = bus_rd_en_q;
    assign bus_wr_en   = bus_wr_en_q;
    assign bus_address = bus_address_q;
    assign bus_wr_data = bus_wr_data_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;

endmodule
